// File: rtl/input_conditioner.sv
// Purpose: per-channel synchronizer plus consecutive-stability debounce filter with edge pulses, bounce statistics and a sticky settle-timeout fault.
// Latency: a clean step reaches level_out and the edge pulse SYNC_STAGES+STABLE_CYCLES clock edges after raw_in is first sampled.
// Backpressure: none; every channel samples raw_in on every clock and the pulses are single-cycle, never held.
module input_conditioner #(
    parameter int              N_CH              = 3,
    parameter int              SYNC_STAGES       = 2,
    parameter int              STABLE_CYCLES     = 64,
    parameter int              MAX_SETTLE_CYCLES = 200000,
    parameter logic [N_CH-1:0] RESET_LEVEL       = '0,
    parameter int              BCNT_W            = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_CH-1:0]          raw_in,
    input  logic [N_CH-1:0]          fault_clear,
    output logic [N_CH-1:0]          level_out,
    output logic [N_CH-1:0]          rise_pulse,
    output logic [N_CH-1:0]          fall_pulse,
    output logic [N_CH-1:0]          settling,
    output logic [N_CH*BCNT_W-1:0]   bounce_count,
    output logic [N_CH-1:0]          unstable_fault
);

    // Counter widths sized so the terminal values are representable.
    localparam int STAB_W   = $clog2(STABLE_CYCLES + 1);
    localparam int SETTLE_W = $clog2(MAX_SETTLE_CYCLES + 1);

    // stab_cnt holds STABLE_CYCLES-1 on the cycle before the commit edge,
    // so the commit happens on the edge where the count would reach STABLE_CYCLES.
    localparam logic [STAB_W-1:0]   STAB_ONE    = STAB_W'(1);
    localparam logic [STAB_W-1:0]   STAB_LAST   = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1);
    localparam logic [SETTLE_W-1:0] SETTLE_MAX  = SETTLE_W'(MAX_SETTLE_CYCLES);
    localparam logic [SETTLE_W-1:0] SETTLE_PRE  = SETTLE_W'(MAX_SETTLE_CYCLES - 1);
    localparam logic [BCNT_W-1:0]   BCNT_ONE    = BCNT_W'(1);
    localparam logic [BCNT_W-1:0]   BCNT_MAX    = '1;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } state_e;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch

        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;

        state_e                 state_q,  state_d;
        logic                   cand_q,   cand_d;
        logic                   level_q,  level_d;
        logic [STAB_W-1:0]      stab_q,   stab_d;
        logic [SETTLE_W-1:0]    settle_q, settle_d;
        logic [BCNT_W-1:0]      bcnt_q,   bcnt_d;
        logic                   rise_q,   rise_d;
        logic                   fall_q,   fall_d;
        logic                   fault_q,  fault_d;
        logic                   fault_set;

        // Shift the asynchronous input through the synchronizer chain.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                sync_q <= {SYNC_STAGES{RESET_LEVEL[g]}};
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in[g]};
            end
        end

        assign s = sync_q[SYNC_STAGES-1];

        // Debounce FSM and its counters: state register.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                state_q  <= ST_STABLE;
                cand_q   <= RESET_LEVEL[g];
                level_q  <= RESET_LEVEL[g];
                stab_q   <= '0;
                settle_q <= '0;
                bcnt_q   <= '0;
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
                fault_q  <= 1'b0;
            end else begin
                state_q  <= state_d;
                cand_q   <= cand_d;
                level_q  <= level_d;
                stab_q   <= stab_d;
                settle_q <= settle_d;
                bcnt_q   <= bcnt_d;
                rise_q   <= rise_d;
                fall_q   <= fall_d;
                fault_q  <= fault_d;
            end
        end

        // Debounce FSM next-state: track a candidate level until it has been
        // seen for STABLE_CYCLES consecutive samples, counting bounces and
        // settling time along the way.
        always_comb begin
            state_d   = state_q;
            cand_d    = cand_q;
            level_d   = level_q;
            stab_d    = stab_q;
            settle_d  = settle_q;
            bcnt_d    = bcnt_q;
            rise_d    = 1'b0;
            fall_d    = 1'b0;
            fault_set = 1'b0;

            case (state_q)
                ST_STABLE: begin
                    if (s != level_q) begin
                        state_d  = ST_SETTLING;
                        cand_d   = s;
                        stab_d   = STAB_ONE;
                        settle_d = SETTLE_ONE;
                        bcnt_d   = '0;
                    end
                end

                ST_SETTLING: begin
                    if (settle_q != SETTLE_MAX) begin
                        settle_d = settle_q + SETTLE_ONE;
                    end
                    // Asserted on the edge where settle_cnt reaches its limit
                    // and kept asserted while it sits saturated, so a clear
                    // cannot win while the channel is still stuck settling.
                    if (settle_q >= SETTLE_PRE) begin
                        fault_set = 1'b1;
                    end

                    if (s != cand_q) begin
                        cand_d = s;
                        stab_d = STAB_ONE;
                        if (bcnt_q != BCNT_MAX) begin
                            bcnt_d = bcnt_q + BCNT_ONE;
                        end
                    end else if (stab_q == STAB_LAST) begin
                        state_d = ST_STABLE;
                        // A candidate equal to the current level is a
                        // rejected glitch: leave the level alone, no pulse.
                        if (cand_q != level_q) begin
                            level_d = cand_q;
                            rise_d  = cand_q;
                            fall_d  = ~cand_q;
                        end
                    end else begin
                        stab_d = stab_q + STAB_ONE;
                    end
                end

                default: begin
                    state_d = ST_STABLE;
                end
            endcase

            // Sticky fault: set has priority over the synchronous clear.
            if (fault_set) begin
                fault_d = 1'b1;
            end else if (fault_clear[g]) begin
                fault_d = 1'b0;
            end else begin
                fault_d = fault_q;
            end
        end

        assign level_out[g]                     = level_q;
        assign rise_pulse[g]                    = rise_q;
        assign fall_pulse[g]                    = fall_q;
        assign settling[g]                      = (state_q == ST_SETTLING);
        assign bounce_count[g*BCNT_W +: BCNT_W] = bcnt_q;
        assign unstable_fault[g]                = fault_q;
    end

endmodule
